// File: rtl/alu_multicycle.sv
// alu_multicycle: 8-opcode ALU with registered G/Zero and a Done pulse per result.
// Define ALU_MUL_EN to make opcode 111 a WIDTH-cycle shift-add multiply; otherwise 111 yields 0.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [2:0]       Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Bus,
  output logic [WIDTH-1:0] G,
  output logic             Done,
  output logic             Busy,
  output logic             Zero
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] alu_r, g_q, g_d;
  logic zero_q, zero_d, done_q, done_d;
  always_comb begin
    alu_r = '0;
    case (Control)
      3'b000:  alu_r = A + Bus;
      3'b001:  alu_r = A - Bus;
      3'b010:  alu_r = A & Bus;
      3'b011:  alu_r = {WIDTH{A < Bus}};
      3'b100:  alu_r = A | Bus;
      3'b101:  alu_r = A ^ Bus;
      3'b110:  alu_r = A << Bus[SW-1:0];
      default: alu_r = '0;
    endcase
  end
`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_nx;
  logic [SW-1:0] cnt_q, cnt_d;
  // Operands are latched at Start, so input changes during MUL cannot reach the product.
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (Start && Control == 3'b111) begin
        state_d  = MUL;
        acc_d    = '0;
        mcand_d  = A;
        mplier_d = Bus;
        cnt_d    = '0;
      end else if (Start) begin
        g_d    = alu_r;
        zero_d = alu_r == '0;
        done_d = 1'b1;
      end
    end else begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SW'(1);
      if (cnt_q == SW'(WIDTH - 1)) begin
        state_d = IDLE;
        g_d     = acc_nx;
        zero_d  = acc_nx == '0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
  assign Busy = state_q == MUL;
`else
  always_comb begin
    g_d    = Start ? alu_r : g_q;
    zero_d = Start ? alu_r == '0 : zero_q;
    done_d = Start;
  end
  assign Busy = 1'b0;
`endif
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      g_q    <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      g_q    <= g_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end
  assign G    = g_q;
  assign Zero = zero_q;
  assign Done = done_q;
endmodule
